// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmit framer.
// The state enum is common to the framer and any logic that observes its progress.
package bpsk_pkg;

    localparam int LEN_BITS = 8;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GUARD
    } framer_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bpsk_bit_timer.sv
// Sample counter that marks the last clock of each transmitted bit.
// Held at zero while disabled so each frame starts on a fresh bit.
module bpsk_bit_timer #(
    parameter int SAMPLES_PER_BIT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic boundary
);

    localparam int CNT_W = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [CNT_W-1:0] tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_reg <= '0;
        end else if (!en || tick_reg == LAST_TICK) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + 1'b1;
        end
    end

    assign boundary = en && (tick_reg == LAST_TICK);

endmodule

// File: rtl/bpsk_tx_framer.sv
// Frame sequencer feeding the BPSK modem: preamble, sync word, length byte,
// payload bytes (MSB first) and trailing guard zeros, one bit per SAMPLES_PER_BIT clocks.
module bpsk_tx_framer
    import bpsk_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 20,
    parameter int PREAMBLE_BITS   = 16,
    parameter int SYNC_BITS       = 16,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD = SYNC_BITS'(DEFAULT_SYNC_WORD),
    parameter int GUARD_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                bit_data_out,
    output logic                bit_en_out
);

    localparam int MAX_FIELD = max4(PREAMBLE_BITS, SYNC_BITS, GUARD_BITS, 8);
    localparam int IDX_W     = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;

    localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST  = IDX_W'(SYNC_BITS - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST  = IDX_W'(7);
    localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_BITS - 1);

    framer_state_t        state_reg,   state_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [LEN_BITS-1:0]  len_cnt_reg, len_cnt_next;
    logic [7:0]           shift_reg,   shift_next;
    logic [SYNC_BITS-1:0] sync_reg,    sync_next;
    logic                 done_reg,    done_next;

    logic       boundary;
    logic [7:0] fetch_byte;

    bpsk_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .boundary (boundary)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= '0;
            len_cnt_reg <= '0;
            shift_reg   <= '0;
            sync_reg    <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            len_cnt_reg <= len_cnt_next;
            shift_reg   <= shift_next;
            sync_reg    <= sync_next;
            done_reg    <= done_next;
        end
    end

    // A missing byte is replaced by zeros so the frame keeps its advertised length.
    assign fetch_byte = byte_valid ? byte_data : 8'h00;

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        len_cnt_next = len_cnt_reg;
        shift_next   = shift_reg;
        sync_next    = sync_reg;
        done_next    = 1'b0;
        byte_ready   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_PREAMBLE;
                    bit_idx_next = '0;
                    len_cnt_next = len;
                    shift_next   = len;
                    sync_next    = SYNC_WORD;
                end
            end
            ST_PREAMBLE: begin
                if (boundary) begin
                    if (bit_idx_reg == PRE_LAST) begin
                        state_next   = ST_SYNC;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    sync_next = sync_reg << 1;
                    if (bit_idx_reg == SYNC_LAST) begin
                        state_next   = ST_HEADER;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            // Header and payload bytes share the same shift-out and fetch path.
            ST_HEADER, ST_PAYLOAD: begin
                if (boundary) begin
                    if (bit_idx_reg == BYTE_LAST) begin
                        bit_idx_next = '0;
                        if (len_cnt_reg != '0) begin
                            state_next   = ST_PAYLOAD;
                            byte_ready   = 1'b1;
                            shift_next   = fetch_byte;
                            len_cnt_next = len_cnt_reg - 1'b1;
                        end else begin
                            state_next = ST_GUARD;
                        end
                    end else begin
                        shift_next   = shift_reg << 1;
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (boundary) begin
                    if (bit_idx_reg == GUARD_LAST) begin
                        state_next   = ST_IDLE;
                        bit_idx_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bit_data_out = 1'b0;
        unique case (state_reg)
            ST_PREAMBLE:           bit_data_out = ~bit_idx_reg[0];
            ST_SYNC:               bit_data_out = sync_reg[SYNC_BITS-1];
            ST_HEADER, ST_PAYLOAD: bit_data_out = shift_reg[7];
            default:               bit_data_out = 1'b0;
        endcase
    end

    assign busy       = (state_reg != ST_IDLE);
    assign bit_en_out = busy;
    assign done       = done_reg;
    assign underrun   = byte_ready & ~byte_valid;

endmodule
